// File: rtl/qar_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : qar_mem_arbiter
// Desc    : Shares one valid/ready memory port between instruction fetch and
//           data access. Data has priority, fetch starvation is bounded, and
//           a stalled transfer ends with an error completion after TIMEOUT.
//           Optional statistics counters are built when QAR_ARB_STATS_EN is
//           defined.
// Rev     : 1.0  initial release
// ============================================================================
module qar_mem_arbiter #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    STARVE_LIMIT = 4,
    parameter int                    TIMEOUT      = 64,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA     = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ready,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_valid,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  m_valid,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_ready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  m_src,
    output logic                  err_timeout,
    output logic [31:0]           stat_i_grants,
    output logic [31:0]           stat_d_grants,
    output logic [31:0]           stat_wait_cycles
);

    localparam int              TIMER_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] C_TIMER_LAST = TIMER_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [3:0]      C_STARVE_LIM = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_starve;
    logic [TIMER_W-1:0]      r_timer;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;

    logic                    w_busy;
    logic                    w_timeout;
    logic                    w_done;
    logic                    w_grant_i;
    logic                    w_grant_d;
    logic                    w_arb_point;
    logic                    w_i_pend;
    logic [DATA_WIDTH-1:0]   w_cpl_data;

    // Outputs are forced quiet while reset is held, not just after the edge.
    assign w_busy      = rst_n && (r_state != ST_IDLE);
    assign w_timeout   = (TIMEOUT != 0) && w_busy && !m_ready && (r_timer == C_TIMER_LAST);
    assign w_done      = w_busy && (m_ready || w_timeout);
    assign w_cpl_data  = m_ready ? m_rdata : ERR_DATA;
    // A fetch valid seen while fetch owns the port belongs to its own transfer.
    assign w_i_pend    = i_valid && (r_state != ST_BUSY_I);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_arb_point = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_arb_point = 1'b1;
                if (d_valid && (!i_valid || (r_starve < C_STARVE_LIM))) begin
                    w_grant_d = 1'b1;
                end else if (i_valid) begin
                    w_grant_i = 1'b1;
                end
            end
            ST_BUSY_I: begin
                if (w_done) begin
                    w_arb_point = 1'b1;
                    w_grant_d   = d_valid;
                end
            end
            ST_BUSY_D: begin
                if (w_done) begin
                    w_arb_point = 1'b1;
                    w_grant_i   = i_valid;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_grant_d) begin
            w_state_nxt = ST_BUSY_D;
        end else if (w_grant_i) begin
            w_state_nxt = ST_BUSY_I;
        end else if (w_arb_point) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_starve <= 4'd0;
            r_timer  <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_d) begin
                r_we    <= d_we;
                r_addr  <= d_addr;
                r_wdata <= d_wdata;
            end else if (w_grant_i) begin
                r_we    <= 1'b0;
                r_addr  <= i_addr;
                r_wdata <= '0;
            end
            if (w_grant_i) begin
                r_starve <= 4'd0;
            end else if (w_grant_d) begin
                r_starve <= !w_i_pend ? 4'd0 :
                            (r_starve == 4'd15) ? 4'd15 : r_starve + 4'd1;
            end else if (w_arb_point) begin
                r_starve <= 4'd0;
            end
            if (w_grant_i || w_grant_d) begin
                r_timer <= '0;
            end else if (w_busy && !m_ready) begin
                r_timer <= r_timer + TIMER_W'(1);
            end
        end
    end

    assign m_valid     = w_busy;
    assign m_src       = w_busy && (r_state == ST_BUSY_D);
    assign m_we        = w_busy && r_we;
    assign m_addr      = w_busy ? r_addr  : '0;
    assign m_wdata     = w_busy ? r_wdata : '0;
    assign i_ready     = w_done && (r_state == ST_BUSY_I);
    assign d_ready     = w_done && (r_state == ST_BUSY_D);
    assign i_rdata     = i_ready ? w_cpl_data : '0;
    assign d_rdata     = d_ready ? w_cpl_data : '0;
    assign err_timeout = w_timeout;

`ifdef QAR_ARB_STATS_EN
    logic [31:0] r_stat_i;
    logic [31:0] r_stat_d;
    logic [31:0] r_stat_wait;
    logic        w_i_wait;
    logic        w_d_wait;

    assign w_i_wait = i_valid && (r_state != ST_BUSY_I);
    assign w_d_wait = d_valid && (r_state != ST_BUSY_D);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_i    <= 32'd0;
            r_stat_d    <= 32'd0;
            r_stat_wait <= 32'd0;
        end else begin
            if (w_grant_i) r_stat_i <= r_stat_i + 32'd1;
            if (w_grant_d) r_stat_d <= r_stat_d + 32'd1;
            r_stat_wait <= r_stat_wait + 32'(w_i_wait) + 32'(w_d_wait);
        end
    end

    assign stat_i_grants    = rst_n ? r_stat_i    : 32'd0;
    assign stat_d_grants    = rst_n ? r_stat_d    : 32'd0;
    assign stat_wait_cycles = rst_n ? r_stat_wait : 32'd0;
`else
    assign stat_i_grants    = 32'd0;
    assign stat_d_grants    = 32'd0;
    assign stat_wait_cycles = 32'd0;
`endif

endmodule
`default_nettype wire
